fir_tap_sequencer: RTL and testbench

- Upstream neighbour of the per-band MAC (`compute`).
- Stores the most recent NUMBER_OF_TAPS input samples in a circular buffer.
- On each accepted sample, walks the taps newest-first, one per enabled clock, driving `delay_filter_in`, the coefficient slot index and `phase_min`.
- One instance serves each band's FIR.

---
 rtl/fir_eq_pkg.sv | 20 ++
 rtl/sample_ring_buffer.sv | 37 +++
 rtl/fir_tap_sequencer.sv | 102 ++++++++++
 tb/tb_fir_tap_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fir_eq_pkg.sv
// Shared defaults, sequencer state type and pointer helper for the per-band FIR datapath.
package fir_eq_pkg;

    localparam int FILTER_IN_BITS_DEF = 16;
    localparam int NUMBER_OF_TAPS_DEF = 64;
    localparam int COEFF_BITS_DEF     = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // (base - phase) mod n without relying on a power-of-two depth.
    function automatic int unsigned ptr_wrap_dec(input int unsigned base,
                                                 input int unsigned phase,
                                                 input int unsigned n);
        return (base >= phase) ? (base - phase) : (base + n - phase);
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Circular sample history: one write port advancing wr_ptr, one registered read port.
module sample_ring_buffer #(
    parameter  int DATA_BITS = 16,
    parameter  int DEPTH     = 64,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic [ADDR_BITS-1:0] wr_ptr,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_data <= '0;
        end else if (en) begin
            if (wr_en) begin
                mem_q[wr_ptr] <= wr_data;
                wr_ptr        <= (wr_ptr == ADDR_BITS'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            // Zero when not reading so the downstream accumulator is left untouched.
            rd_data <= rd_en ? mem_q[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Presents the stored taps newest-first to the per-band MAC, one per enabled clock.
// Optional sticky overrun detection is built when FIR_SEQ_OVERRUN_EN is defined.
module fir_tap_sequencer
    import fir_eq_pkg::*;
#(
    parameter  int FILTER_IN_BITS = FILTER_IN_BITS_DEF,
    parameter  int NUMBER_OF_TAPS = NUMBER_OF_TAPS_DEF,
    localparam int ADDR_BITS      = $clog2(NUMBER_OF_TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_enable,
    input  logic [FILTER_IN_BITS-1:0] sample_in,
    input  logic                      sample_valid,
    output logic                      ready,
    output logic [FILTER_IN_BITS-1:0] delay_filter_in,
    output logic [ADDR_BITS-1:0]      coeff_addr,
    output logic                      phase_min,
    output logic                      tap_valid,
    output logic                      overrun
);

    seq_state_e           state_q;
    logic [ADDR_BITS-1:0] phase_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 accept;
    logic                 last_tap;

    assign ready    = (state_q == IDLE);
    assign accept   = sample_valid & ready & clk_enable;
    assign last_tap = (phase_q == ADDR_BITS'(NUMBER_OF_TAPS - 1));
    assign rd_addr  = ADDR_BITS'(ptr_wrap_dec(32'(base_q), 32'(phase_q),
                                              32'(NUMBER_OF_TAPS)));

    sample_ring_buffer #(
        .DATA_BITS (FILTER_IN_BITS),
        .DEPTH     (NUMBER_OF_TAPS)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (clk_enable),
        .wr_en   (accept),
        .wr_data (sample_in),
        .wr_ptr  (wr_ptr),
        .rd_en   (state_q == RUN),
        .rd_addr (rd_addr),
        .rd_data (delay_filter_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            base_q     <= '0;
            coeff_addr <= '0;
            phase_min  <= 1'b0;
            tap_valid  <= 1'b0;
        end else if (clk_enable) begin
            case (state_q)
                IDLE: begin
                    coeff_addr <= '0;
                    phase_min  <= 1'b0;
                    tap_valid  <= 1'b0;
                    if (accept) begin
                        base_q  <= wr_ptr;
                        phase_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    coeff_addr <= phase_q;
                    phase_min  <= (phase_q == '0);
                    tap_valid  <= 1'b1;
                    if (last_tap) begin
                        state_q <= IDLE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FIR_SEQ_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (clk_enable && sample_valid && !ready) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed and randomized bench for fir_tap_sequencer against a frame-level history model.
module tb_fir_tap_sequencer;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AB = 2;
`ifdef FIR_SEQ_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_enable = 1'b0;
    logic          sample_valid = 1'b0;
    logic [W-1:0]  sample_in = '0;
    logic          ready;
    logic [W-1:0]  delay_filter_in;
    logic [AB-1:0] coeff_addr;
    logic          phase_min;
    logic          tap_valid;
    logic          overrun;

    fir_tap_sequencer #(
        .FILTER_IN_BITS (W),
        .NUMBER_OF_TAPS (N)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_enable      (clk_enable),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .ready           (ready),
        .delay_filter_in (delay_filter_in),
        .coeff_addr      (coeff_addr),
        .phase_min       (phase_min),
        .tap_valid       (tap_valid),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [W-1:0] data;
        int           addr;
    } tap_t;

    // Model: every accepted sample in order, and the taps still owed for the current frame.
    tap_t         pending[$];
    logic [W-1:0] history[$];
    logic [W-1:0] e_data;
    logic [AB-1:0] e_addr;
    logic          e_pmin, e_tv, e_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        pending.delete();
        history.delete();
        e_data = '0; e_addr = '0; e_pmin = 1'b0; e_tv = 1'b0; e_ovr = 1'b0;
    endtask

    task automatic model_edge();
        tap_t t;
        int   idx;
        bit   was_ready;
        if (!clk_enable) return;
        was_ready = (pending.size() == 0);
        if (sample_valid && !was_ready && OVR_EN) e_ovr = 1'b1;
        if (!was_ready) begin
            t      = pending.pop_front();
            e_data = t.data;
            e_addr = AB'(t.addr);
            e_pmin = (t.addr == 0);
            e_tv   = 1'b1;
        end else begin
            e_data = '0; e_addr = '0; e_pmin = 1'b0; e_tv = 1'b0;
            if (sample_valid) begin
                history.push_back(sample_in);
                for (int i = 0; i < N; i++) begin
                    idx = history.size() - 1 - i;
                    t.data = (idx >= 0) ? history[idx] : '0;
                    t.addr = i;
                    pending.push_back(t);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " data"},  32'(delay_filter_in), 32'(e_data));
        check({tag, " addr"},  32'(coeff_addr),      32'(e_addr));
        check({tag, " pmin"},  32'(phase_min),       32'(e_pmin));
        check({tag, " tv"},    32'(tap_valid),       32'(e_tv));
        check({tag, " ready"}, 32'(ready),           32'(pending.size() == 0));
        check({tag, " ovr"},   32'(overrun),         32'(e_ovr));
    endtask

    task automatic cycle(input string tag, input bit v, input logic [W-1:0] s, input bit en);
        sample_valid = v;
        sample_in    = s;
        clk_enable   = en;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int pm_count;
    logic [W-1:0] exp5 [N];

    initial begin
        model_reset();
        apply_reset("reset");

        // Single sample into empty history: 5,0,0,0.
        exp5[0] = 16'd5; exp5[1] = '0; exp5[2] = '0; exp5[3] = '0;
        cycle("acc5", 1'b1, 16'd5, 1'b1);
        for (int i = 0; i < N; i++) begin
            cycle("tap5", 1'b0, '0, 1'b1);
            check("t5 data", 32'(delay_filter_in), 32'(exp5[i]));
            check("t5 addr", 32'(coeff_addr), 32'(i));
        end
        check("t5 ready", 32'(ready), 32'd1);

        // Back-to-back 1..5 after a fresh reset; last frame reads 5,4,3,2.
        apply_reset("reset2");
        for (int s = 1; s <= 5; s++) begin
            cycle("b2b acc", 1'b1, 16'(s), 1'b1);
            for (int i = 0; i < N; i++) cycle("b2b tap", 1'b0, '0, 1'b1);
        end

        // sample_valid held: one frame start per N+1 enabled cycles.
        pm_count = 0;
        for (int i = 0; i < 15; i++) begin
            cycle("hold", 1'b1, 16'(100 + i), 1'b1);
            if (phase_min) pm_count++;
        end
        check("hold frames", 32'(pm_count), 32'd3);
        for (int i = 0; i < N; i++) cycle("hold drain", 1'b0, '0, 1'b1);

        // Enable gaps while tap 0 is presented.
        cycle("gap acc", 1'b1, 16'h0abc, 1'b1);
        cycle("gap t0", 1'b0, '0, 1'b1);
        cycle("gap off", 1'b0, '0, 1'b0);
        cycle("gap off", 1'b0, '0, 1'b0);
        check("gap pmin held", 32'(phase_min), 32'd1);
        for (int i = 1; i < N; i++) cycle("gap tap", 1'b0, '0, 1'b1);

        // Reset mid-frame, then 7 into cleared history.
        cycle("mid acc", 1'b1, 16'd9, 1'b1);
        cycle("mid t0", 1'b0, '0, 1'b1);
        cycle("mid t1", 1'b0, '0, 1'b1);
        #2;
        apply_reset("mid reset");
        cycle("acc7", 1'b1, 16'd7, 1'b1);
        for (int i = 0; i < N; i++) cycle("tap7", 1'b0, '0, 1'b1);
        check("t7 last data", 32'(delay_filter_in), 32'd0);

        // Dropped sample during RUN.
        cycle("ovr acc", 1'b1, 16'd3, 1'b1);
        cycle("ovr t0", 1'b0, '0, 1'b1);
        cycle("ovr pulse", 1'b1, 16'h55, 1'b1);
        for (int i = 0; i < N; i++) cycle("ovr after", 1'b0, '0, 1'b1);
        check("ovr sticky", 32'(overrun), 32'(OVR_EN));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
